// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared types and helpers for the matrix add/subtract engine
//
// Contents:
//   state_t        engine control states (IDLE, RUN, DONE)
//   operand_msb()  MSB of element k in an ELEM_W-packed operand bus (element 0 at the top)
//   result_msb()   MSB of element k in a RES_W-packed result bus (element 0 at the top)
//   lanes_divide() true when the lane count tiles the matrix exactly
package mat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int operand_msb(input int k, input int ne, input int elem_w);
        return (ne - k) * elem_w - 1;
    endfunction

    function automatic int result_msb(input int k, input int ne, input int elem_w);
        return (ne - k) * (elem_w + 1) - 1;
    endfunction

    function automatic bit lanes_divide(input int ne, input int lanes);
        return (lanes > 0) && ((ne % lanes) == 0);
    endfunction

endpackage

// File: rtl/mat_lane_alu.sv
// rtl/mat_lane_alu.sv - one element lane: add or subtract with range detection
//
// Ports:
//   a, b          ELEM_W-bit unsigned operands
//   sub           0 = a+b, 1 = a-b
//   result        RES_W-bit result (extended sum / two's-complement difference,
//                 or clamped to the ELEM_W range when MAT_ADDSUB_SAT_EN is defined)
//   out_of_range  true result does not fit the unsigned ELEM_W range
// Build option: MAT_ADDSUB_SAT_EN selects saturating arithmetic.
module mat_lane_alu #(
    parameter int ELEM_W = 4,
    localparam int RES_W = ELEM_W + 1
) (
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    input  logic              sub,
    output logic [RES_W-1:0]  result,
    output logic              out_of_range
);

    logic [RES_W-1:0] sum;
    logic [RES_W-1:0] diff;
    logic             borrow;

    always_comb begin
        sum          = {1'b0, a} + {1'b0, b};
        diff         = {1'b0, a} - {1'b0, b};
        borrow       = (a < b);
        out_of_range = sub ? borrow : sum[ELEM_W];
`ifdef MAT_ADDSUB_SAT_EN
        if (sub) begin
            result = borrow ? '0 : diff;
        end else begin
            result = sum[ELEM_W] ? {1'b0, {ELEM_W{1'b1}}} : sum;
        end
`else
        result = sub ? diff : sum;
`endif
    end

endmodule

// File: rtl/mat_addsub_engine.sv
// rtl/mat_addsub_engine.sv - N x N matrix add/subtract engine, LANES elements per beat
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   start        request an operation (accepted in IDLE or DONE)
//   sub          0 = A+B, 1 = A-B, sampled on accept
//   mat_a, mat_b NE*ELEM_W operands, element 0 in the top ELEM_W bits
//   mat_out      NE*RES_W result, element 0 in the top RES_W bits
//   busy, done   high in RUN / DONE
//   range_flag   sticky: some element left the unsigned ELEM_W range
// Build option: MAT_ADDSUB_SAT_EN (saturating lanes, see mat_lane_alu).
module mat_addsub_engine
    import mat_pkg::*;
#(
    parameter int ELEM_W = 4,
    parameter int N      = 4,
    parameter int LANES  = 2,
    localparam int NE    = N * N,
    localparam int BEATS = NE / LANES,
    localparam int RES_W = ELEM_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic [NE*ELEM_W-1:0] mat_a,
    input  logic [NE*ELEM_W-1:0] mat_b,
    output logic [NE*RES_W-1:0]  mat_out,
    output logic                busy,
    output logic                done,
    output logic                range_flag
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W = (NE > 1) ? $clog2(NE) : 1;

    if (!lanes_divide(NE, LANES)) begin : g_bad_lanes
        $error("mat_addsub_engine: LANES must divide N*N");
    end

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     beat_q;
    logic [NE*ELEM_W-1:0] a_q, b_q;
    logic                 sub_q;
    logic                 range_q;
    logic [RES_W-1:0]     res_q    [NE];
    logic [ELEM_W-1:0]    a_elem   [NE];
    logic [ELEM_W-1:0]    b_elem   [NE];
    logic [IDX_W-1:0]     lane_idx [LANES];
    logic [RES_W-1:0]     lane_res [LANES];
    logic [LANES-1:0]     lane_oor;
    logic                 accept;
    logic                 last_beat;

    // Fixed-position views of the latched operands and the result register.
    for (genvar k = 0; k < NE; k++) begin : g_elem
        assign a_elem[k] = a_q[operand_msb(k, NE, ELEM_W) -: ELEM_W];
        assign b_elem[k] = b_q[operand_msb(k, NE, ELEM_W) -: ELEM_W];
        assign mat_out[result_msb(k, NE, ELEM_W) -: RES_W] = res_q[k];
    end

    // Lane l of beat j handles element j*LANES + l.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = IDX_W'(int'(beat_q) * LANES + l);

        mat_lane_alu #(
            .ELEM_W(ELEM_W)
        ) u_alu (
            .a            (a_elem[lane_idx[l]]),
            .b            (b_elem[lane_idx[l]]),
            .sub          (sub_q),
            .result       (lane_res[l]),
            .out_of_range (lane_oor[l])
        );
    end

    assign accept     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_beat  = (beat_q == CNT_W'(BEATS - 1));
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign range_flag = range_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_RUN;
            ST_RUN:  if (last_beat) state_d = ST_DONE;
            ST_DONE: if (start)     state_d = ST_RUN;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            range_q <= 1'b0;
            for (int k = 0; k < NE; k++) res_q[k] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= mat_a;
                b_q     <= mat_b;
                sub_q   <= sub;
                beat_q  <= '0;
                range_q <= 1'b0;
                for (int k = 0; k < NE; k++) res_q[k] <= '0;
            end else if (state_q == ST_RUN) begin
                for (int l = 0; l < LANES; l++) res_q[lane_idx[l]] <= lane_res[l];
                range_q <= range_q | (|lane_oor);
                beat_q  <= last_beat ? '0 : beat_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mat_addsub_engine.sv
// tb/tb_mat_addsub_engine.sv - self-checking bench for mat_addsub_engine (LANES=2 and LANES=16)
module tb_mat_addsub_engine;

    localparam int NE    = 16;
    localparam int RES_W = 5;

    logic        clk = 1'b0;
    logic        rst, start, sub;
    logic [63:0] mat_a, mat_b;
    logic [79:0] mat_out, mat_out16;
    logic        busy, done, range_flag;
    logic        busy16, done16, range16;

    int n_cmp = 0;
    int n_bad = 0;

    int         ea [NE];
    int         eb [NE];
    logic [4:0] exp_res [NE];
    logic       exp_flag;

    always #5 clk = ~clk;

    mat_addsub_engine #(.ELEM_W(4), .N(4), .LANES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .mat_a(mat_a), .mat_b(mat_b),
        .mat_out(mat_out), .busy(busy), .done(done), .range_flag(range_flag)
    );

    mat_addsub_engine #(.ELEM_W(4), .N(4), .LANES(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .mat_a(mat_a), .mat_b(mat_b),
        .mat_out(mat_out16), .busy(busy16), .done(done16), .range_flag(range16)
    );

    function automatic logic [4:0] field(input logic [79:0] v, input int k);
        logic [79:0] t;
        t = v >> ((NE - 1 - k) * RES_W);
        return t[4:0];
    endfunction

    function automatic logic [63:0] pack(input int e [NE]);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < NE; k++) v = {v[59:0], 4'(e[k])};
        return v;
    endfunction

    // Reference: plain integer arithmetic on the element lists.
    task automatic model(input logic s);
        int r;
        exp_flag = 1'b0;
        for (int k = 0; k < NE; k++) begin
            if (!s) begin
                r = ea[k] + eb[k];
                if (r > 15) exp_flag = 1'b1;
`ifdef MAT_ADDSUB_SAT_EN
                if (r > 15) r = 15;
`endif
            end else begin
                r = ea[k] - eb[k];
                if (r < 0) exp_flag = 1'b1;
`ifdef MAT_ADDSUB_SAT_EN
                if (r < 0) r = 0;
`else
                r = (r + 32) % 32;
`endif
            end
            exp_res[k] = 5'(r);
        end
    endtask

    task automatic rand_ops();
        for (int k = 0; k < NE; k++) begin
            ea[k] = int'($urandom_range(15));
            eb[k] = int'($urandom_range(15));
        end
    endtask

    task automatic launch(input logic s);
        mat_a = pack(ea);
        mat_b = pack(eb);
        sub   = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (done !== 1'b1 && cycles < 40);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; mat_a = '0; mat_b = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (mat_out !== '0) begin n_bad++; $display("FAIL reset_mat_out got %h want 0", mat_out); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (range_flag !== 1'b0) begin n_bad++; $display("FAIL reset_range got %b want 0", range_flag); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_basic();
        for (int k = 0; k < NE; k++) begin ea[k] = 3; eb[k] = 2; end
        model(1'b0);
        launch(1'b0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i <= 8) begin
                n_cmp++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_bad++; $display("FAIL basic_run_cycle%0d busy/done got %b%b want 10", i, busy, done);
                end
            end
            if (i == 1) begin
                n_cmp++; if (field(mat_out, 0) !== 5'd0) begin n_bad++; $display("FAIL basic_beat0_early got %h want 0", field(mat_out, 0)); end
            end
            if (i == 2) begin
                n_cmp++; if (field(mat_out, 1) !== exp_res[1]) begin n_bad++; $display("FAIL basic_beat0_elem1 got %h want %h", field(mat_out, 1), exp_res[1]); end
                n_cmp++; if (field(mat_out, 2) !== 5'd0) begin n_bad++; $display("FAIL basic_beat1_early got %h want 0", field(mat_out, 2)); end
            end
        end
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_done_cycle9 busy/done got %b%b want 01", busy, done); end
        for (int k = 0; k < NE; k++) begin
            n_cmp++; if (field(mat_out, k) !== exp_res[k]) begin n_bad++; $display("FAIL basic_elem%0d got %h want %h", k, field(mat_out, k), exp_res[k]); end
        end
        n_cmp++; if (range_flag !== exp_flag) begin n_bad++; $display("FAIL basic_range got %b want %b", range_flag, exp_flag); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || field(mat_out, 15) !== exp_res[15]) begin n_bad++; $display("FAIL basic_hold done %b elem15 %h want 1 %h", done, field(mat_out, 15), exp_res[15]); end
    endtask

    task automatic test_fixed(input string name, input logic s, input int kind);
        int cyc;
        for (int k = 0; k < NE; k++) begin
            if (kind == 0) begin ea[k] = 15; eb[k] = 1; end
            else begin ea[k] = int'($urandom_range(15)); eb[k] = ea[k]; end
        end
        if (kind == 1) begin ea[0] = 3; eb[0] = 5; end
        model(s);
        launch(s);
        wait_done(cyc);
        n_cmp++; if (cyc !== 9) begin n_bad++; $display("FAIL %s_latency got %0d want 9", name, cyc); end
        for (int k = 0; k < NE; k++) begin
            n_cmp++; if (field(mat_out, k) !== exp_res[k]) begin n_bad++; $display("FAIL %s_elem%0d got %h want %h", name, k, field(mat_out, k), exp_res[k]); end
        end
        n_cmp++; if (range_flag !== exp_flag) begin n_bad++; $display("FAIL %s_range got %b want %b", name, range_flag, exp_flag); end
    endtask

    task automatic test_random();
        int cyc;
        logic s;
        for (int it = 0; it < 8; it++) begin
            rand_ops();
            s = 1'($urandom_range(1));
            model(s);
            launch(s);
            wait_done(cyc);
            n_cmp++; if (cyc !== 9) begin n_bad++; $display("FAIL rand%0d_latency got %0d want 9", it, cyc); end
            for (int k = 0; k < NE; k++) begin
                n_cmp++; if (field(mat_out, k) !== exp_res[k]) begin n_bad++; $display("FAIL rand%0d_elem%0d got %h want %h", it, k, field(mat_out, k), exp_res[k]); end
            end
            n_cmp++; if (range_flag !== exp_flag) begin n_bad++; $display("FAIL rand%0d_range got %b want %b", it, range_flag, exp_flag); end
        end
    endtask

    task automatic test_ignore_during_run();
        int cyc;
        rand_ops();
        model(1'b1);
        launch(1'b1);
        cyc = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            cyc = i;
            if (i <= 6) begin
                mat_a = {$urandom, $urandom};
                mat_b = {$urandom, $urandom};
                sub   = 1'($urandom_range(1));
                start = (i == 3 || i == 4);
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) break;
        end
        n_cmp++; if (cyc !== 9 || done !== 1'b1) begin n_bad++; $display("FAIL ignore_latency got %0d done %b want 9 1", cyc, done); end
        for (int k = 0; k < NE; k++) begin
            n_cmp++; if (field(mat_out, k) !== exp_res[k]) begin n_bad++; $display("FAIL ignore_elem%0d got %h want %h", k, field(mat_out, k), exp_res[k]); end
        end
        n_cmp++; if (range_flag !== exp_flag) begin n_bad++; $display("FAIL ignore_range got %b want %b", range_flag, exp_flag); end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        rand_ops();
        launch(1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_state busy/done got %b%b want 00", busy, done); end
        n_cmp++; if (mat_out !== '0) begin n_bad++; $display("FAIL abort_mat_out got %h want 0", mat_out); end
        n_cmp++; if (range_flag !== 1'b0) begin n_bad++; $display("FAIL abort_range got %b want 0", range_flag); end
        rst = 1'b0;
        rand_ops();
        model(1'b1);
        launch(1'b1);
        wait_done(cyc);
        n_cmp++; if (cyc !== 9) begin n_bad++; $display("FAIL after_abort_latency got %0d want 9", cyc); end
        for (int k = 0; k < NE; k++) begin
            n_cmp++; if (field(mat_out, k) !== exp_res[k]) begin n_bad++; $display("FAIL after_abort_elem%0d got %h want %h", k, field(mat_out, k), exp_res[k]); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int a2 [NE];
        int b2 [NE];
        rand_ops();
        model(1'b0);
        mat_a = pack(ea); mat_b = pack(eb); sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NE; k++) begin
            a2[k] = int'($urandom_range(15));
            b2[k] = int'($urandom_range(15));
        end
        mat_a = pack(a2); mat_b = pack(b2); sub = 1'b1;
        wait_done(cyc);
        n_cmp++; if (cyc !== 9) begin n_bad++; $display("FAIL b2b_first_latency got %0d want 9", cyc); end
        for (int k = 0; k < NE; k++) begin
            n_cmp++; if (field(mat_out, k) !== exp_res[k]) begin n_bad++; $display("FAIL b2b_first_elem%0d got %h want %h", k, field(mat_out, k), exp_res[k]); end
        end
        ea = a2; eb = b2;
        model(1'b1);
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL b2b_restart busy/done got %b%b want 10", busy, done); end
        n_cmp++; if (mat_out !== '0 || range_flag !== 1'b0) begin n_bad++; $display("FAIL b2b_clear mat_out %h range %b want 0 0", mat_out, range_flag); end
        wait_done(cyc);
        n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL b2b_second_latency got %0d want 8", cyc); end
        for (int k = 0; k < NE; k++) begin
            n_cmp++; if (field(mat_out, k) !== exp_res[k]) begin n_bad++; $display("FAIL b2b_second_elem%0d got %h want %h", k, field(mat_out, k), exp_res[k]); end
        end
        n_cmp++; if (range_flag !== exp_flag) begin n_bad++; $display("FAIL b2b_second_range got %b want %b", range_flag, exp_flag); end
    endtask

    task automatic test_single_beat();
        int cyc;
        logic s;
        for (int it = 0; it < 3; it++) begin
            rand_ops();
            s = 1'($urandom_range(1));
            model(s);
            launch(s);
            @(negedge clk);
            n_cmp++; if (busy16 !== 1'b1 || done16 !== 1'b0) begin n_bad++; $display("FAIL lanes16_run%0d busy/done got %b%b want 10", it, busy16, done16); end
            @(negedge clk);
            n_cmp++; if (done16 !== 1'b1) begin n_bad++; $display("FAIL lanes16_done%0d got %b want 1", it, done16); end
            for (int k = 0; k < NE; k++) begin
                n_cmp++; if (field(mat_out16, k) !== exp_res[k]) begin n_bad++; $display("FAIL lanes16_%0d_elem%0d got %h want %h", it, k, field(mat_out16, k), exp_res[k]); end
            end
            n_cmp++; if (range16 !== exp_flag) begin n_bad++; $display("FAIL lanes16_%0d_range got %b want %b", it, range16, exp_flag); end
            wait_done(cyc);
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_fixed("add_ovf", 1'b0, 0);
        test_fixed("sub_neg", 1'b1, 1);
        test_random();
        test_ignore_during_run();
        test_reset_mid_run();
        test_back_to_back();
        test_single_beat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mat_addsub_engine.md
# mat_addsub_engine

Parametrised matrix add/subtract engine for the matrix calculator datapath. It latches two N×N operand matrices on a start handshake and processes LANES elements per cycle. Results are written into an indexed, element-aligned output register, and a sticky range flag is kept. It generalises the fixed 4×4, 2-lane, shift-register add path and sits alongside the multiply path under the top-level controller.

## Interface
Parameters:
- ELEM_W, 4: operand element width, unsigned.
- N, 4: matrix dimension (N×N elements, row-major).
- LANES, 2: elements computed per cycle. Must divide N*N; elaboration error otherwise.
- Derived: NE = N*N, BEATS = NE/LANES, RES_W = ELEM_W+1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request an operation; accepted only in IDLE or DONE
- sub  in  1  0 = A+B, 1 = A−B; sampled on accept
- mat_a  in  NE*ELEM_W  operand A; element k at bits [(NE−k)*ELEM_W−1 -: ELEM_W]
- mat_b  in  NE*ELEM_W  operand B; same packing as mat_a
- mat_out  out  NE*RES_W  result; element k at bits [(NE−k)*RES_W−1 -: RES_W]
- busy  out  1  high in RUN
- done  out  1  high in DONE
- range_flag  out  1  sticky: some element left the ELEM_W unsigned range this operation

## Operation
- States: IDLE, RUN, DONE. The state type lives in the package.
- IDLE:
  - start=1 → accept. Latch mat_a, mat_b and sub into internal registers.
  - Clear mat_out and range_flag, set beat counter to 0, go to RUN.
- RUN:
  - Beat j computes elements j*LANES … j*LANES+LANES−1 from the latched operands only; input changes during RUN are ignored.
  - Each result is written to its own mat_out field. Nothing is shifted.
  - The counter increments each beat. After beat BEATS−1, go to DONE.
- DONE:
  - done=1 and mat_out is stable.
  - start=1 → accept exactly as in IDLE (back-to-back operation). Otherwise stay in DONE.
- start during RUN is ignored. It is not queued.
- Arithmetic per element, default build:
  - Add: zero-extended sum, range 0 … 2^(ELEM_W+1)−2.
  - Sub: A−B modulo 2^RES_W, two's complement in RES_W bits (e.g. 3−5 = 5'b11110).
- range_flag is set by either of:
  - an add result ≥ 2^ELEM_W;
  - a sub with A < B.
  - Once set, it holds until the next accept or reset.

## Timing
- Reset values: state IDLE, mat_out 0, busy 0, done 0, range_flag 0, counter 0.
- Reset mid-RUN aborts the operation: next cycle is IDLE with all outputs zeroed.
- Accept at edge t. RUN covers cycles t+1 … t+BEATS. done rises at edge t+BEATS+1.
- Total latency is BEATS+1 cycles, i.e. 9 for the default configuration.
- Beat j's fields become visible one edge after that beat. range_flag updates on the same edge as the offending field.
- Back-to-back: start high in DONE at edge u → busy=1, done=0 and mat_out=0 from u+1.
- LANES = NE: a single RUN cycle, latency 2.

## Configuration
- MAT_ADDSUB_SAT_EN defined: results saturate to the unsigned ELEM_W range.
  - Add clamps to 2^ELEM_W−1.
  - Sub clamps to 0.
  - Field MSB is always 0.
  - range_flag still sets on any clamp.
- MAT_ADDSUB_SAT_EN undefined: wrap/extended arithmetic as in Operation.

## Structure
- Package mat_pkg: state enum, element-slice helper functions for both packings, and the LANES-divides-NE check.
- Sub-module mat_lane_alu: one lane, instantiated LANES times in a generate loop.
  - Inputs: ELEM_W-bit a, b, and sub.
  - Outputs: RES_W result and an out_of_range bit.
  - Saturation logic under MAT_ADDSUB_SAT_EN is inside this sub-module.
- Top level: FSM, beat counter, operand registers and indexed write of mat_out.

## Test plan
All scenarios use defaults N=4, ELEM_W=4, LANES=2 unless stated.
1. A = all 4'h3, B = all 4'h2, sub=0, start one cycle → busy for 8 cycles, done on cycle 9, every field 5'd5, range_flag=0.
2. A = all 4'hF, B = all 4'h1, add → fields 5'h10, range_flag=1. With MAT_ADDSUB_SAT_EN: fields 5'h0F, range_flag=1.
3. Sub with A elem0 = 3, B elem0 = 5, others equal → elem0 = 5'b11110 (0 with SAT_EN), others 0, range_flag=1.
4. Change mat_a and mat_b and pulse start during RUN → results match the originally latched operands; start is ignored; done still at cycle 9.
5. Assert rst at RUN beat 4 → next cycle IDLE, mat_out=0, busy=0, done=0. A new start then completes normally.
6. Start held high in DONE → immediate restart: done drops for 8 cycles, then second result valid. Rerun with LANES=16: latency 2.
